// File: rtl/dpy_arbiter.sv
// dpy_arbiter: shares one 8-digit seven-segment display between NUM_REQ
// requesters. Request/grant handshake with round-robin fairness and a
// minimum hold time so a pattern stays up long enough to be read.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   req[NUM_REQ]       level request per requester
//   req_number/req_dp  flattened per-requester digit data (32b / 8b each)
//   grant[NUM_REQ]     one-hot grant or all-zero
//   owner[3]           index of current/last owner
//   busy               high while a grant is asserted
//   number_out/dp_out  registered data to dpy_scan
//
// Optional build macro: DPY_ARB_OWNER_TAG_EN -- when defined, the leftmost
// digit shows the owner index with its decimal point lit while owned.
module dpy_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [32*NUM_REQ-1:0]  req_number,
  input  logic [8*NUM_REQ-1:0]   req_dp,
  output logic [NUM_REQ-1:0]     grant,
  output logic [2:0]             owner,
  output logic                   busy,
  output logic [31:0]            number_out,
  output logic [7:0]             dp_out
);

  typedef enum logic [1:0] {IDLE, HOLD, OPEN} state_e;

  localparam logic [31:0] CNT_MAX = 32'(HOLD_CYCLES - 1);

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [2:0]           owner_q, owner_d;
  logic [2:0]           rr_q, rr_d;
  logic                 busy_q, busy_d;
  logic [31:0]          cnt_q, cnt_d;
  logic [31:0]          number_q, number_d;
  logic [7:0]           dp_q, dp_d;

  logic [NUM_REQ-1:0]   cand;
  logic                 pick_vld;
  logic [2:0]           pick_idx;
  logic                 owner_req;
  logic                 others;
  logic [31:0]          sel_number;
  logic [7:0]           sel_dp;
  logic                 new_grant;
  logic                 rel;

  // Candidates exclude the current owner; grant_q is zero in IDLE so every
  // request competes there. Since rr == owner while granted, the search
  // naturally visits the owner last.
  always_comb begin
    int idx;
    idx      = 0;
    cand     = req & ~grant_q;
    pick_vld = 1'b0;
    pick_idx = rr_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!pick_vld && cand[idx]) begin
        pick_vld = 1'b1;
        pick_idx = 3'(idx);
      end
    end
  end

  // grant_q is one-hot on owner, so this is the owner's own request bit.
  assign owner_req = |(req & grant_q);
  assign others    = |cand;

  always_comb begin
    sel_number = '0;
    sel_dp     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == 3'(i)) begin
        sel_number = req_number[32*i +: 32];
        sel_dp     = req_dp[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    new_grant = 1'b0;
    rel       = 1'b0;

    case (state_q)
      IDLE: if (pick_vld) new_grant = 1'b1;
      HOLD: begin
        // Release beats the hold timer; other requesters are ignored here.
        if (!owner_req)            rel     = 1'b1;
        else if (cnt_q == CNT_MAX) state_d = OPEN;
        else                       cnt_d   = cnt_q + 32'd1;
      end
      OPEN: begin
        // Another requester takes over directly, with no idle gap,
        // whether or not the owner still wants the display.
        if (others)          new_grant = 1'b1;
        else if (!owner_req) rel       = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (rel) begin
      state_d = IDLE;
      grant_d = '0;
      cnt_d   = '0;
    end
    if (new_grant) begin
      state_d = HOLD;
      cnt_d   = '0;
      owner_d = pick_idx;
      rr_d    = pick_idx;
      for (int i = 0; i < NUM_REQ; i++) grant_d[i] = (pick_idx == 3'(i));
    end
    busy_d = |grant_d;
  end

  // Data follows the registered owner, so a new owner's data appears one
  // cycle after its grant. In IDLE the last pattern is held (no flicker).
  always_comb begin
    number_d = number_q;
    dp_d     = dp_q;
    if (|grant_q) begin
      number_d = sel_number;
      dp_d     = sel_dp;
`ifdef DPY_ARB_OWNER_TAG_EN
      number_d[31:28] = {1'b0, owner_q};
      dp_d[7]         = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_q     <= 3'(NUM_REQ - 1);
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      number_q <= '0;
      dp_q     <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      number_q <= number_d;
      dp_q     <= dp_d;
    end
  end

  assign grant      = grant_q;
  assign owner      = owner_q;
  assign busy       = busy_q;
  assign number_out = number_q;
  assign dp_out     = dp_q;

endmodule

// File: tb/tb_dpy_arbiter.sv
// Directed bench for dpy_arbiter (NUM_REQ=4, HOLD_CYCLES=4). Each step
// pushes the expected post-edge outputs onto a scoreboard queue, clocks
// the DUT, then pops and compares.
module tb_dpy_arbiter;

  localparam int NR = 4;
  localparam int HC = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req;
  logic [32*NR-1:0] req_number;
  logic [8*NR-1:0] req_dp;
  logic [NR-1:0]   grant;
  logic [2:0]      owner;
  logic            busy;
  logic [31:0]     number_out;
  logic [7:0]      dp_out;

  dpy_arbiter #(.NUM_REQ(NR), .HOLD_CYCLES(HC)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_number(req_number),
    .req_dp(req_dp), .grant(grant), .owner(owner), .busy(busy),
    .number_out(number_out), .dp_out(dp_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [3:0]  grant;
    logic [2:0]  owner;
    logic        busy;
    logic [31:0] num;
    logic [7:0]  dp;
  } exp_t;

  exp_t sb[$];
  int compared   = 0;
  int mismatched = 0;

  logic [31:0] nv[NR];
  logic [7:0]  dv[NR];

  // Expected display data when owner o is loaded.
  function automatic logic [31:0] en(input int o);
    logic [31:0] v;
    v = nv[o];
`ifdef DPY_ARB_OWNER_TAG_EN
    v[31:28] = {1'b0, 3'(o)};
`endif
    return v;
  endfunction

  function automatic logic [7:0] ed(input int o);
    logic [7:0] v;
    v = dv[o];
`ifdef DPY_ARB_OWNER_TAG_EN
    v[7] = 1'b1;
`endif
    return v;
  endfunction

  task automatic chk(input string tag, input string what,
                     input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s.%s: got %h expected %h", tag, what, obs, exp);
    end
  endtask

  task automatic tick(input string tag, input logic [3:0] g, input logic [2:0] o,
                      input logic b, input logic [31:0] num, input logic [7:0] dp);
    exp_t e;
    exp_t p;
    e.tag = tag; e.grant = g; e.owner = o; e.busy = b; e.num = num; e.dp = dp;
    sb.push_back(e);
    @(posedge clk);
    #1;
    p = sb.pop_front();
    chk(p.tag, "grant",  32'(grant),  32'(p.grant));
    chk(p.tag, "owner",  32'(owner),  32'(p.owner));
    chk(p.tag, "busy",   32'(busy),   32'(p.busy));
    chk(p.tag, "number", number_out,  p.num);
    chk(p.tag, "dp",     32'(dp_out), 32'(p.dp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    nv[0] = 32'h1234_5678; dv[0] = 8'h01;
    nv[1] = 32'hAAAA_0001; dv[1] = 8'h02;
    nv[2] = 32'hFFFF_FFFF; dv[2] = 8'h00;
    nv[3] = 32'hCCCC_0003; dv[3] = 8'h08;
    req_number = {nv[3], nv[2], nv[1], nv[0]};
    req_dp     = {dv[3], dv[2], dv[1], dv[0]};

    // Reset
    rst_n = 1'b0; req = 4'b0000;
    tick("rst_a", 4'b0000, 3'd0, 1'b0, 32'h0, 8'h0);
    tick("rst_b", 4'b0000, 3'd0, 1'b0, 32'h0, 8'h0);
    rst_n = 1'b1;

    // Single requester: grant after deciding cycle, data one cycle later
    req = 4'b0001;
    tick("s1_grant", 4'b0001, 3'd0, 1'b1, 32'h0, 8'h0);
    tick("s1_data",  4'b0001, 3'd0, 1'b1, en(0), ed(0));
    req = 4'b0000;
    tick("s1_rel",   4'b0000, 3'd0, 1'b0, en(0), ed(0));
    tick("s1_idle",  4'b0000, 3'd0, 1'b0, en(0), ed(0));

    // Fresh reset so rr = 3, then simultaneous 1 and 2
    rst_n = 1'b0;
    tick("rst2", 4'b0000, 3'd0, 1'b0, 32'h0, 8'h0);
    rst_n = 1'b1;
    req = 4'b0110;
    tick("rr_g1",   4'b0010, 3'd1, 1'b1, 32'h0, 8'h0);
    tick("rr_d1",   4'b0010, 3'd1, 1'b1, en(1), ed(1));
    tick("rr_h2",   4'b0010, 3'd1, 1'b1, en(1), ed(1));
    tick("rr_h3",   4'b0010, 3'd1, 1'b1, en(1), ed(1));
    tick("rr_open", 4'b0010, 3'd1, 1'b1, en(1), ed(1));
    tick("rr_pre1", 4'b0100, 3'd2, 1'b1, en(1), ed(1));
    tick("rr_d2",   4'b0100, 3'd2, 1'b1, en(2), ed(2));
    tick("rr_h2b",  4'b0100, 3'd2, 1'b1, en(2), ed(2));
    tick("rr_h3b",  4'b0100, 3'd2, 1'b1, en(2), ed(2));
    tick("rr_openb",4'b0100, 3'd2, 1'b1, en(2), ed(2));
    tick("rr_pre2", 4'b0010, 3'd1, 1'b1, en(2), ed(2));

    // Owner 1 releases mid-HOLD (counter 2) with req2 pending
    tick("rel_c1",  4'b0010, 3'd1, 1'b1, en(1), ed(1));
    tick("rel_c2",  4'b0010, 3'd1, 1'b1, en(1), ed(1));
    req = 4'b0100;
    tick("rel_idle",    4'b0000, 3'd1, 1'b0, en(1), ed(1));
    tick("rel_regrant", 4'b0100, 3'd2, 1'b1, en(1), ed(1));
    tick("rel_d2",      4'b0100, 3'd2, 1'b1, en(2), ed(2));
    tick("hold_c2",     4'b0100, 3'd2, 1'b1, en(2), ed(2));
    tick("hold_c3",     4'b0100, 3'd2, 1'b1, en(2), ed(2));
    tick("open_enter",  4'b0100, 3'd2, 1'b1, en(2), ed(2));
    tick("open_stay",   4'b0100, 3'd2, 1'b1, en(2), ed(2));

    // Owner drops in OPEN while req3 waits: direct handoff, no zero cycle
    req = 4'b1000;
    tick("handoff",   4'b1000, 3'd3, 1'b1, en(2), ed(2));
    tick("handoff_d", 4'b1000, 3'd3, 1'b1, en(3), ed(3));
    tick("h3_c2",     4'b1000, 3'd3, 1'b1, en(3), ed(3));
    tick("h3_c3",     4'b1000, 3'd3, 1'b1, en(3), ed(3));
    req = 4'b1111;
    tick("h3_open",   4'b1000, 3'd3, 1'b1, en(3), ed(3));

    // Reset during OPEN with all requesting
    rst_n = 1'b0;
    tick("rst_mid", 4'b0000, 3'd0, 1'b0, 32'h0, 8'h0);
    rst_n = 1'b1;
    tick("rst_regrant", 4'b0001, 3'd0, 1'b1, 32'h0, 8'h0);
    tick("rst_d0",      4'b0001, 3'd0, 1'b1, en(0), ed(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
